// File: rtl/tff_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tff_counter_pkg
// Brief    : Mode constants and the clamp helper used by the counter and timers
// Revision : 1.0 - initial release
// ============================================================================
package tff_counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    function automatic logic [31:0] clamp(input logic [31:0] val, input logic [31:0] max);
        return (val > max) ? max : val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tff_cell.sv
`default_nettype none
// ============================================================================
// Module   : tff_cell
// Brief    : Single T flip-flop with asynchronous active-high reset
// Revision : 1.0 - initial release
// ============================================================================
module tff_cell #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RST_BIT;
        end else if (t) begin
            r_q <= ~r_q;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/tff_counter.sv
`default_nettype none
// ============================================================================
// Module   : tff_counter
// Brief    : Up/down counter with load, clear, modulus and wrap/saturate mode,
//            realised as a bank of toggle cells
// Revision : 1.0 - initial release
// ============================================================================
module tff_counter
    import tff_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int RST_VAL  = 0,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] c_rst = WIDTH'(RST_VAL);
    localparam logic             c_sat = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] w_q_n;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_load_clamped;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_wrap_n;
    logic             r_wrap;

    assign w_at_max       = (q == c_max);
    assign w_at_min       = (q == '0);
    assign w_load_clamped = WIDTH'(clamp(32'(load_val), 32'(MAX_VAL)));

    always_comb begin
        w_q_n    = q;
        w_wrap_n = 1'b0;
        if (clr) begin
            w_q_n = '0;
        end else if (load) begin
            w_q_n = w_load_clamped;
        end else if (en) begin
            if (up_dn) begin
                if (!w_at_max) begin
                    w_q_n = q + 1'b1;
                end else if (!c_sat) begin
                    w_q_n    = '0;
                    w_wrap_n = 1'b1;
                end
            end else begin
                if (!w_at_min) begin
                    w_q_n = q - 1'b1;
                end else if (!c_sat) begin
                    w_q_n    = c_max;
                    w_wrap_n = 1'b1;
                end
            end
        end
    end

    // Each cell flips exactly the bits that differ between now and next.
    assign w_t = q ^ w_q_n;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell #(
            .RST_BIT (c_rst[i])
        ) u_cell (
            .clk (clk),
            .rst (rst),
            .t   (w_t[i]),
            .q   (q[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_n;
        end
    end

    assign wrap = r_wrap;
    assign tc   = en & ((up_dn & w_at_max) | (~up_dn & w_at_min));

endmodule
`default_nettype wire

// File: tb/tb_tff_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tff_counter
// Brief    : Three counter configurations driven in lockstep against an
//            arithmetic reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_tff_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       clr = 1'b0;

    logic [3:0] q_a, q_b, q_c;
    logic       tc_a, tc_b, tc_c;
    logic       wrap_a, wrap_b, wrap_c;

    int vectors = 0;
    int fails   = 0;

    // a: modulo-10 wrap, resets to 5; b: modulo-10 saturate; c: full 4-bit wrap
    int c_max[3] = '{9, 9, 15};
    bit c_sat[3] = '{1'b0, 1'b1, 1'b0};
    int c_rst[3] = '{5, 0, 0};

    int mq[3];
    bit mw[3];

    logic [3:0] qv[3];
    logic       tcv[3];
    logic       wv[3];

    assign qv[0] = q_a;   assign qv[1] = q_b;   assign qv[2] = q_c;
    assign tcv[0] = tc_a; assign tcv[1] = tc_b; assign tcv[2] = tc_c;
    assign wv[0] = wrap_a; assign wv[1] = wrap_b; assign wv[2] = wrap_c;

    always #5 clk = ~clk;

    tff_counter #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(5), .SATURATE(0)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clr(clr), .q(q_a), .tc(tc_a), .wrap(wrap_a));

    tff_counter #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(0), .SATURATE(1)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clr(clr), .q(q_b), .tc(tc_b), .wrap(wrap_b));

    tff_counter #(.WIDTH(4), .MAX_VAL(15), .RST_VAL(0), .SATURATE(0)) u_dut_c (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clr(clr), .q(q_c), .tc(tc_c), .wrap(wrap_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Count range is 0..m, so wrapping is simply arithmetic modulo m+1.
    function automatic int model_next(input int k, input int q, input bit e, input bit u,
                                      input bit ld, input int lv, input bit cl,
                                      output bit w);
        int m = c_max[k];
        w = 1'b0;
        if (cl) return 0;
        if (ld) return (lv > m) ? m : lv;
        if (!e) return q;
        if (u) begin
            if (c_sat[k]) return (q + 1 > m) ? m : q + 1;
            w = (q == m);
            return (q + 1) % (m + 1);
        end
        if (c_sat[k]) return (q == 0) ? 0 : q - 1;
        w = (q == 0);
        return (q + m) % (m + 1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k] = c_rst[k];
            mw[k] = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_q%0d", tag, k), 32'(qv[k]), mq[k]);
            check($sformatf("%s_wrap%0d", tag, k), 32'(wv[k]), 32'(mw[k]));
        end
    endtask

    task automatic step(input string tag, input bit e, input bit u, input bit ld,
                        input int lv, input bit cl);
        en = e; up_dn = u; load = ld; load_val = lv[3:0]; clr = cl;
        #1;
        for (int k = 0; k < 3; k++) begin
            bit exp_tc = e && (u ? (mq[k] == c_max[k]) : (mq[k] == 0));
            check($sformatf("%s_tc%0d", tag, k), 32'(tcv[k]), 32'(exp_tc));
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            bit w;
            mq[k] = model_next(k, mq[k], e, u, ld, lv, cl, w);
            mw[k] = w;
        end
        #1;
        check_state(tag);
    endtask

    initial begin
        logic [3:0] prev_c;

        // Asynchronous reset between edges takes effect at once.
        #3 rst = 1'b1;
        #1;
        model_reset();
        check("rst_async_qa", 32'(q_a), 5);
        check_state("rst_async");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) step("rst_up", 1, 1, 0, 0, 0);
        check("rst_up_end", 32'(q_a), 9);

        // Wrap up from 8.
        step("ld8", 0, 1, 1, 8, 0);
        for (int i = 0; i < 3; i++) step("wrap_up", 1, 1, 0, 0, 0);

        // Wrap down from 1 (saturating instance pins at 0).
        step("ld1", 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) step("wrap_dn", 1, 0, 0, 0, 0);
        check("sat_floor", 32'(q_b), 0);

        // Priority clr > load > en, then clamp of out-of-range load.
        step("pri_clr", 1, 1, 1, 7, 1);
        step("pri_ld", 1, 1, 1, 7, 0);
        step("pri_clamp", 0, 1, 1, 14, 0);
        check("clamp_a", 32'(q_a), 9);
        check("noclamp_c", 32'(q_c), 14);

        // Hold, then direction changes every cycle.
        step("ld4", 0, 1, 1, 4, 0);
        for (int i = 0; i < 3; i++) step("hold", 0, i[0], 0, 0, 0);
        step("dir_up", 1, 1, 0, 0, 0);
        step("dir_dn", 1, 0, 0, 0, 0);
        step("dir_up2", 1, 1, 0, 0, 0);

        // Full power-of-two range: 14 -> 15 -> 0, all bits toggle on the wrap.
        step("ld14", 0, 1, 1, 14, 0);
        step("full_up", 1, 1, 0, 0, 0);
        prev_c = q_c;
        step("full_wrap", 1, 1, 0, 0, 0);
        check("all_toggle", 32'(prev_c ^ q_c), 15);

        // Alternating direction at the boundary gives back-to-back wraps.
        step("ld0", 0, 1, 1, 0, 0);
        step("alt_dn", 1, 0, 0, 0, 0);
        step("alt_up", 1, 1, 0, 0, 0);

        // Reset mid-count overrides and holds across an edge.
        step("pre_rst", 1, 1, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_state("rst_mid");
        @(posedge clk);
        #1;
        check_state("rst_hold");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            bit e  = ($urandom_range(0, 7) != 0);
            bit u  = $urandom_range(0, 1) != 0;
            bit ld = ($urandom_range(0, 15) == 0);
            bit cl = ($urandom_range(0, 31) == 0);
            int lv = $urandom_range(0, 15);
            step("rand", e, u, ld, lv, cl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
